// File: rtl/crosswalk_pkg.sv
// crosswalk_pkg: shared definitions for the pedestrian request controller.
//   - Per-channel FSM state encodings (2-bit, legacy-compatible localparams).
//   - Default timing constants for the top-level parameters.
//   - cnt_width(): width of the shared wait/lockout counter.
// Optional feature macro used by the design: CROSSWALK_PRESS_QUEUE_EN.
package crosswalk_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] SERVING = 2'd2;
    localparam logic [1:0] LOCKOUT = 2'd3;

    localparam int unsigned LOCKOUT_SEC_DEF  = 5;
    localparam int unsigned MAX_WAIT_SEC_DEF = 30;
    localparam int unsigned SYNC_STAGES_DEF  = 2;

    // Wide enough to hold max(a, b); never zero bits wide.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        if (m == 0) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/crosswalk_req_channel.sv
// crosswalk_req_channel: one pedestrian request channel.
//   Edge-detects the debounced button, holds the request until the walk light
//   is served, then applies a post-walk lockout measured in 1 s ticks.
// Ports:
//   clk_i       system clock (clk_50_mhz)
//   rst_ni      asynchronous active-low reset
//   tick_i      one-cycle 1 s tick
//   sig_i       debounced button level, active-high
//   walk_s_i    synchronised walk-light feedback
//   crosswalk_o request to the intersection
//   wait_o      request pending
//   urgent_o    request pending for at least MAX_WAIT_SEC ticks
// Macro CROSSWALK_PRESS_QUEUE_EN: when defined, a press during lockout is
// remembered and becomes a request as soon as the lockout expires.
module crosswalk_req_channel
    import crosswalk_pkg::*;
#(
    parameter int unsigned LOCKOUT_SEC  = LOCKOUT_SEC_DEF,
    parameter int unsigned MAX_WAIT_SEC = MAX_WAIT_SEC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic sig_i,
    input  logic walk_s_i,
    output logic crosswalk_o,
    output logic wait_o,
    output logic urgent_o
);

    localparam int unsigned CntW = cnt_width(LOCKOUT_SEC, MAX_WAIT_SEC);
    localparam logic [CntW-1:0] LockLoad = CntW'(LOCKOUT_SEC);
    localparam logic [CntW-1:0] MaxWait  = CntW'(MAX_WAIT_SEC);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    logic [1:0]      state_q, state_d;
    logic            sig_q, sig_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            press;
`ifdef CROSSWALK_PRESS_QUEUE_EN
    logic            queued_q, queued_d;
`endif

    assign press = sig_i & ~sig_q;

    always_comb begin
        sig_d      = sig_i;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        lock_cnt_d = lock_cnt_q;
`ifdef CROSSWALK_PRESS_QUEUE_EN
        queued_d   = queued_q;
`endif
        case (state_q)
            IDLE: begin
                // A press that coincides with an active walk is already served.
                if (press && !walk_s_i) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (walk_s_i) begin
                    state_d    = SERVING;
                    wait_cnt_d = '0;
                end else if (tick_i && (wait_cnt_q != MaxWait)) begin
                    wait_cnt_d = wait_cnt_q + CntOne;
                end
            end
            SERVING: begin
                if (!walk_s_i) begin
                    if (LOCKOUT_SEC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = LOCKOUT;
                        lock_cnt_d = LockLoad;
                    end
                end
            end
            LOCKOUT: begin
`ifdef CROSSWALK_PRESS_QUEUE_EN
                if (press) begin
                    queued_d = 1'b1;
                end
`endif
                if (tick_i) begin
                    if (lock_cnt_q == CntOne) begin
                        lock_cnt_d = '0;
`ifdef CROSSWALK_PRESS_QUEUE_EN
                        // A press on the expiring cycle still counts as queued.
                        state_d  = (queued_q || press) ? PENDING : IDLE;
                        queued_d = 1'b0;
`else
                        state_d  = IDLE;
`endif
                    end else begin
                        lock_cnt_d = lock_cnt_q - CntOne;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sig_q      <= 1'b1;  // a button held through reset is not a press
            wait_cnt_q <= '0;
            lock_cnt_q <= '0;
`ifdef CROSSWALK_PRESS_QUEUE_EN
            queued_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sig_q      <= sig_d;
            wait_cnt_q <= wait_cnt_d;
            lock_cnt_q <= lock_cnt_d;
`ifdef CROSSWALK_PRESS_QUEUE_EN
            queued_q   <= queued_d;
`endif
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign crosswalk_o = (state_q == PENDING);
    assign wait_o      = (state_q == PENDING);
    assign urgent_o    = (state_q == PENDING) && (wait_cnt_q == MaxWait);

endmodule

// File: rtl/crosswalk_request_ctrl.sv
// crosswalk_request_ctrl: pedestrian request stage in front of the
// intersection controller. Synchronises the 1 Hz timer clock and both walk
// feedbacks into clk_50_mhz, derives a 1 s tick, and runs one request channel
// per direction.
// Ports:
//   clk_50_mhz, reset_n          system clock, asynchronous active-low reset
//   clk_1_hz                     1 Hz timer clock, sampled as data
//   nrth_xwalk_sig/west_xwalk_sig debounced button levels
//   walk_nrth/walk_west          walk-light feedback (1 Hz domain)
//   crosswalk_0/crosswalk_1      north/west requests to the intersection
//   wait_nrth/wait_west          request pending indicators
//   urgent_nrth/urgent_west      request pending for MAX_WAIT_SEC ticks
// Macro CROSSWALK_PRESS_QUEUE_EN enables queueing of presses made during lockout.
module crosswalk_request_ctrl
    import crosswalk_pkg::*;
#(
    parameter int unsigned LOCKOUT_SEC  = LOCKOUT_SEC_DEF,
    parameter int unsigned MAX_WAIT_SEC = MAX_WAIT_SEC_DEF,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF  // must be >= 2
) (
    input  logic clk_50_mhz,
    input  logic reset_n,
    input  logic clk_1_hz,
    input  logic nrth_xwalk_sig,
    input  logic west_xwalk_sig,
    input  logic walk_nrth,
    input  logic walk_west,
    output logic crosswalk_0,
    output logic crosswalk_1,
    output logic wait_nrth,
    output logic wait_west,
    output logic urgent_nrth,
    output logic urgent_west
);

    localparam int unsigned SettleW = $clog2(SYNC_STAGES + 2);
    localparam logic [SettleW-1:0] SettleMax = SettleW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] nrth_sync_q, nrth_sync_d;
    logic [SYNC_STAGES-1:0] west_sync_q, west_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [SettleW-1:0]     settle_q, settle_d;
    logic                   clk_s, tick;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], clk_1_hz};
        nrth_sync_d = {nrth_sync_q[SYNC_STAGES-2:0], walk_nrth};
        west_sync_d = {west_sync_q[SYNC_STAGES-2:0], walk_west};
        clk_prev_d  = clk_s;
        settle_d    = (settle_q == SettleMax) ? settle_q : settle_q + SettleW'(1);
    end

    // Masked until the chain has flushed, so a clk_1_hz that was already high
    // at reset release does not look like a rising edge.
    assign tick = clk_s & ~clk_prev_q & (settle_q == SettleMax);

    always_ff @(posedge clk_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '0;
            nrth_sync_q <= '0;
            west_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            settle_q    <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            nrth_sync_q <= nrth_sync_d;
            west_sync_q <= west_sync_d;
            clk_prev_q  <= clk_prev_d;
            settle_q    <= settle_d;
        end
    end

    crosswalk_req_channel #(
        .LOCKOUT_SEC (LOCKOUT_SEC),
        .MAX_WAIT_SEC(MAX_WAIT_SEC)
    ) u_nrth (
        .clk_i      (clk_50_mhz),
        .rst_ni     (reset_n),
        .tick_i     (tick),
        .sig_i      (nrth_xwalk_sig),
        .walk_s_i   (nrth_sync_q[SYNC_STAGES-1]),
        .crosswalk_o(crosswalk_0),
        .wait_o     (wait_nrth),
        .urgent_o   (urgent_nrth)
    );

    crosswalk_req_channel #(
        .LOCKOUT_SEC (LOCKOUT_SEC),
        .MAX_WAIT_SEC(MAX_WAIT_SEC)
    ) u_west (
        .clk_i      (clk_50_mhz),
        .rst_ni     (reset_n),
        .tick_i     (tick),
        .sig_i      (west_xwalk_sig),
        .walk_s_i   (west_sync_q[SYNC_STAGES-1]),
        .crosswalk_o(crosswalk_1),
        .wait_o     (wait_west),
        .urgent_o   (urgent_west)
    );

endmodule

// File: doc/crosswalk_request_ctrl.md
Name: crosswalk_request_ctrl

Overview:
Pedestrian request stage between the debounced button outputs and the intersection controller's crosswalk_0/crosswalk_1 inputs. It turns button presses into held requests, clears each request once the matching walk light is served, and enforces a post-walk lockout. It also drives "wait" and "urgent" indicators. It runs on clk_50_mhz and samples the 1 Hz timer clock and walk-light feedback as asynchronous data.

Parameters:
LOCKOUT_SEC, 5, ticks after a walk ends during which new presses are not accepted as requests
MAX_WAIT_SEC, 30, ticks spent pending before urgent asserts
SYNC_STAGES, 2, flop depth of each synchroniser (minimum 2)

Ports:
clk_50_mhz  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
clk_1_hz  in  1  master_timer output, sampled as data and used as the 1 s tick source
nrth_xwalk_sig  in  1  debounced north button level, active-high
west_xwalk_sig  in  1  debounced west button level, active-high
walk_nrth  in  1  OR of both north walk lights (1 Hz domain)
walk_west  in  1  OR of both west walk lights (1 Hz domain)
crosswalk_0  out  1  north request to the intersection
crosswalk_1  out  1  west request to the intersection
wait_nrth  out  1  north request pending
wait_west  out  1  west request pending
urgent_nrth  out  1  north request pending for at least MAX_WAIT_SEC
urgent_west  out  1  west request pending for at least MAX_WAIT_SEC

Behaviour:
- Reset
  - Every output is 0 and every synchroniser flop is 0.
  - Both channels are in IDLE and all counters are 0.
  - The button edge-detect registers reset to 1, so a button held through reset release does not count as a press.
- Synchronisers and tick
  - clk_1_hz, walk_nrth and walk_west each pass through a SYNC_STAGES flop chain.
  - tick is a one-cycle pulse on each rising edge of the synchronised clk_1_hz.
  - No tick is generated in the first SYNC_STAGES+1 cycles after reset release.
- Press detection
  - press = sig & ~sig_q, where sig_q is the previous sample.
  - A press is seen on the edge where sig is first sampled high. The request output is high from the following cycle.
- Per-channel FSM (2-bit state)
  - IDLE
    - press while walk_s=0 -> PENDING.
    - press while walk_s=1 is ignored (the walk is already in progress).
  - PENDING
    - crosswalk=1 and wait=1.
    - wait_cnt increments on each tick and saturates at MAX_WAIT_SEC.
    - urgent=1 while wait_cnt==MAX_WAIT_SEC.
    - walk_s=1 -> SERVING; wait_cnt clears.
    - Further presses have no effect.
  - SERVING
    - crosswalk=0, wait=0, urgent=0.
    - walk_s falls -> LOCKOUT with lock_cnt loaded to LOCKOUT_SEC.
    - If LOCKOUT_SEC==0, go directly to IDLE.
  - LOCKOUT
    - lock_cnt decrements on each tick.
    - When lock_cnt==1 and a tick arrives -> IDLE.
    - Presses are handled as described under Optional Feature.
- Timing and concurrency
  - Walk feedback latency is SYNC_STAGES+1 clk_50_mhz cycles, from walk light change to state change.
  - Press and walk rising on the same cycle in IDLE: the press is ignored.
  - The two channels are fully independent; simultaneous presses produce two independent requests.
- Counter width: $clog2(max(LOCKOUT_SEC,MAX_WAIT_SEC)+1), unsigned.
- Reset mid-operation: asynchronous return to the reset state; any pending request is dropped.

Optional Feature:
- Macro: CROSSWALK_PRESS_QUEUE_EN.
- Defined:
  - A press in LOCKOUT sets a per-channel queued flag.
  - When lockout expires, the channel goes to PENDING instead of IDLE and the flag clears.
  - crosswalk asserts on the cycle after the expiring tick.
- Not defined: presses in LOCKOUT are discarded and no queued flag exists.

Decomposition:
- Package crosswalk_pkg holds:
  - the state localparams IDLE=2'd0, PENDING=2'd1, SERVING=2'd2, LOCKOUT=2'd3;
  - the default timing constants.
- Sub-module crosswalk_req_channel holds the edge detect, FSM and counters. It is instantiated twice.
- The top level holds the three synchronisers and the shared tick generator.

Test Plan:
All scenarios use LOCKOUT_SEC=3, MAX_WAIT_SEC=4, SYNC_STAGES=2, and a fast clk_1_hz of period 20 cycles.
- Reset with nrth_xwalk_sig held at 1, then release -> crosswalk_0 stays 0. Drop the input and raise it again -> crosswalk_0=1 and wait_nrth=1 exactly 1 cycle after the rise is sampled.
- North press, walk_nrth held at 0 for 4 ticks -> urgent_nrth=1 on the cycle after the 4th tick. Raise walk_nrth -> crosswalk_0, wait_nrth and urgent_nrth all 0 three cycles later.
- walk_nrth falls, then north presses before the 3rd tick -> crosswalk_0 stays 0. North press after the 3rd tick -> crosswalk_0=1.
- Same as the previous scenario with CROSSWALK_PRESS_QUEUE_EN defined -> the lockout press yields crosswalk_0=1 on the cycle after the 3rd tick.
- Simultaneous north and west presses -> crosswalk_0 and crosswalk_1 both rise on the same cycle. Serving only west clears only crosswalk_1.
- Assert reset_n low while in PENDING -> all outputs 0 immediately, with no clock edge required.
